// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_param
// Purpose  : Parametrised SPI slave.
//            - Word width DATA_W (2..32) and bit order MSB_FIRST are set by parameters.
//            - Supports all four CPOL/CPHA modes.
//            - Supports multi-word bursts within one SSN-low frame.
//            - Has a valid/ready transmit holding register.
//            - Reports underrun and abort with one-cycle pulses.
//            All SPI pins are oversampled in the clk domain.
// Options  : Define SPI_SLAVE_MISO_OE_EN to add the miso_oe output.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_param #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy,
  input  logic              sck,
  input  logic              ssn,
  input  logic              mosi,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic              miso_oe,
`endif
  output logic              miso
);

  localparam int c_cnt_w = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_sck_meta, r_ssck, r_ssck_d;
  logic                r_ssn_meta, r_sssn, r_sssn_d;
  logic                r_mosi_meta, r_smosi;
  logic                r_cpol, r_cpha;
  logic [c_cnt_w-1:0]  r_bit_cnt;
  logic [DATA_W-1:0]   r_rx_sr;
  logic [DATA_W-1:0]   r_tx_sr;
  logic [DATA_W-1:0]   r_rx_data;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
  logic                r_rx_valid, r_underrun, r_abort, r_busy, r_miso;

  logic                w_sck_edge, w_lead, w_trail, w_sample, w_shift;
  logic                w_ssn_fall, w_ssn_rise;
  logic                w_wr, w_load_start, w_word_done, w_load;
  logic                w_load_underrun;
  logic [DATA_W-1:0]   w_load_word;
  logic [DATA_W-1:0]   w_rx_next;
  logic                w_tx_head, w_ld_head;
  logic [DATA_W-1:0]   w_tx_shift, w_ld_shift;

  // Edge classification uses the mode latched at frame start.
  assign w_sck_edge = r_ssck ^ r_ssck_d;
  assign w_lead     = w_sck_edge & (r_ssck_d == r_cpol);
  assign w_trail    = w_sck_edge & (r_ssck == r_cpol);
  assign w_sample   = r_cpha ? w_trail : w_lead;
  assign w_shift    = r_cpha ? w_lead  : w_trail;
  assign w_ssn_fall = r_sssn_d & ~r_sssn;
  assign w_ssn_rise = ~r_sssn_d & r_sssn;

  // Holding-register write and the word that a load would take.
  assign w_wr            = tx_valid & ~r_hold_full;
  assign w_load_word     = r_hold_full ? r_hold : (w_wr ? tx_data : '0);
  assign w_load_underrun = ~r_hold_full & ~w_wr;

  // A load happens at frame start and at every completed word that continues the frame.
  assign w_load_start = (r_state == S_IDLE) & w_ssn_fall;
  assign w_word_done  = (r_state == S_ACTIVE) & w_sample & (r_bit_cnt == c_last_bit);
  assign w_load       = w_load_start | (w_word_done & ~w_ssn_rise);

  // The bit-order dependent shift paths are selected once at elaboration.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_rx_next  = {r_rx_sr[DATA_W-2:0], r_smosi};
      assign w_tx_head  = r_tx_sr[DATA_W-1];
      assign w_tx_shift = {r_tx_sr[DATA_W-2:0], 1'b0};
      assign w_ld_head  = w_load_word[DATA_W-1];
      assign w_ld_shift = {w_load_word[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_rx_next  = {r_smosi, r_rx_sr[DATA_W-1:1]};
      assign w_tx_head  = r_tx_sr[0];
      assign w_tx_shift = {1'b0, r_tx_sr[DATA_W-1:1]};
      assign w_ld_head  = w_load_word[0];
      assign w_ld_shift = {1'b0, w_load_word[DATA_W-1:1]};
    end
  endgenerate

  // Pin synchronisers and the previous-SCK register.
  // The SSN stages reset low: if SSN is still low when reset is released,
  // no falling edge is seen, so the block waits for a fresh select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_meta  <= 1'b0;
      r_ssck      <= 1'b0;
      r_ssck_d    <= 1'b0;
      r_ssn_meta  <= 1'b0;
      r_sssn      <= 1'b0;
      r_sssn_d    <= 1'b0;
      r_mosi_meta <= 1'b0;
      r_smosi     <= 1'b0;
    end else begin
      r_sck_meta  <= sck;
      r_ssck      <= r_sck_meta;
      r_ssck_d    <= r_ssck;
      r_ssn_meta  <= ssn;
      r_sssn      <= r_ssn_meta;
      r_sssn_d    <= r_sssn;
      r_mosi_meta <= mosi;
      r_smosi     <= r_mosi_meta;
    end
  end

  // Transmit holding register.
  // A load empties it. A write in the same cycle as a load bypasses into the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else if (w_wr) begin
      r_hold      <= tx_data;
      r_hold_full <= 1'b1;
    end
  end

  // Frame state machine, which also drives the shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_bit_cnt  <= '0;
      r_rx_sr    <= '0;
      r_tx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      r_busy     <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ssn_fall) begin
            r_state    <= S_ACTIVE;
            r_busy     <= 1'b1;
            r_cpol     <= cpol;
            r_cpha     <= cpha;
            r_bit_cnt  <= '0;
            r_underrun <= w_load_underrun;
            if (cpha) begin
              r_tx_sr <= w_load_word;
              r_miso  <= 1'b0;
            end else begin
              r_tx_sr <= w_ld_shift;
              r_miso  <= w_ld_head;
            end
          end
        end
        S_ACTIVE: begin
          if (w_sample) begin
            r_rx_sr <= w_rx_next;
            if (r_bit_cnt == c_last_bit) begin
              r_rx_data  <= w_rx_next;
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
              if (!w_ssn_rise) begin
                r_underrun <= w_load_underrun;
                if (r_cpha) begin
                  r_tx_sr <= w_load_word;
                end else begin
                  r_tx_sr <= w_ld_shift;
                  r_miso  <= w_ld_head;
                end
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_shift && (r_cpha || (r_bit_cnt != '0))) begin
            // With CPHA=0 the first bit is already on the line from the load,
            // so a shift edge that comes before the word's first sample is ignored.
            r_miso  <= w_tx_head;
            r_tx_sr <= w_tx_shift;
          end
          if (w_ssn_rise) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_miso    <= 1'b0;
            r_tx_sr   <= '0;
            r_bit_cnt <= '0;
            r_abort   <= (r_bit_cnt != '0) && !w_word_done;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;
  assign frame_abort = r_abort;
  assign busy        = r_busy;
  assign miso        = r_miso;
`ifdef SPI_SLAVE_MISO_OE_EN
  assign miso_oe     = r_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_param
// Purpose  : Directed bench for spi_slave_param.
//            Drives an 8-bit MSB-first instance and a 16-bit LSB-first
//            instance from a bit-banged SPI master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_param;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpol = 1'b0, cpha = 1'b0;
  logic        sck = 1'b0, mosi = 1'b0;
  logic        ssn8 = 1'b1, ssn16 = 1'b1;
  logic [7:0]  tx_data8 = '0;
  logic [15:0] tx_data16 = '0;
  logic        tx_valid8 = 1'b0, tx_valid16 = 1'b0;
  logic        tx_ready8, tx_ready16;
  logic [7:0]  rx_data8;
  logic [15:0] rx_data16;
  logic        rx_valid8, rx_valid16, tx_underrun8, tx_underrun16;
  logic        frame_abort8, frame_abort16, busy8, busy16, miso8, miso16;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic        miso_oe8, miso_oe16;
`endif

  int n_vec = 0;
  int n_err = 0;
  int rxv8 = 0, rxv16 = 0, und8 = 0, und16 = 0, abt8 = 0, abt16 = 0;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .MSB_FIRST(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
    .rx_data(rx_data8), .rx_valid(rx_valid8), .tx_underrun(tx_underrun8),
    .frame_abort(frame_abort8), .busy(busy8),
    .sck(sck), .ssn(ssn8), .mosi(mosi),
`ifdef SPI_SLAVE_MISO_OE_EN
    .miso_oe(miso_oe8),
`endif
    .miso(miso8)
  );

  spi_slave_param #(.DATA_W(16), .MSB_FIRST(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
    .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
    .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_underrun(tx_underrun16),
    .frame_abort(frame_abort16), .busy(busy16),
    .sck(sck), .ssn(ssn16), .mosi(mosi),
`ifdef SPI_SLAVE_MISO_OE_EN
    .miso_oe(miso_oe16),
`endif
    .miso(miso16)
  );

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid8)     rxv8++;
    if (rx_valid16)    rxv16++;
    if (tx_underrun8)  und8++;
    if (tx_underrun16) und16++;
    if (frame_abort8)  abt8++;
    if (frame_abort16) abt16++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_write(input bit sel, input logic [31:0] d);
    int t;
    t = 0;
    while (!(sel ? tx_ready16 : tx_ready8) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", (t < 200) ? 32'd1 : 32'd0, 32'd1);
    if (sel) begin
      tx_data16 = d[15:0]; tx_valid16 = 1'b1;
    end else begin
      tx_data8 = d[7:0]; tx_valid8 = 1'b1;
    end
    @(negedge clk);
    tx_valid8 = 1'b0;
    tx_valid16 = 1'b0;
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p; cpha = h; sck = p;
    clk_wait(4);
  endtask

  task automatic frame_start(input bit sel);
    sck = cpol;
    clk_wait(4);
    if (sel) ssn16 = 1'b0; else ssn8 = 1'b0;
    clk_wait(6);
  endtask

  task automatic frame_end(input bit sel);
    clk_wait(4);
    if (sel) ssn16 = 1'b1; else ssn8 = 1'b1;
    clk_wait(8);
  endtask

  // Bit-banged master. It shifts nb bits of a w-bit word and returns what it
  // sampled on MISO.
  task automatic xfer_word(input bit sel, input int w, input int nb, input bit msbf,
                           input logic [31:0] tx_w, output logic [31:0] rx_w);
    int idx;
    rx_w = '0;
    for (int i = 0; i < nb; i++) begin
      idx = msbf ? (w - 1 - i) : i;
      if (!cpha) begin
        mosi = tx_w[idx];
        clk_wait(HALF);
        rx_w[idx] = sel ? miso16 : miso8;
        sck = ~cpol;
        clk_wait(HALF);
        sck = cpol;
      end else begin
        sck = ~cpol;
        mosi = tx_w[idx];
        clk_wait(HALF);
        rx_w[idx] = sel ? miso16 : miso8;
        sck = cpol;
        clk_wait(HALF);
      end
    end
    clk_wait(HALF);
  endtask

  typedef struct {
    bit          sel;
    logic        cp;
    logic        ch;
    logic [31:0] m_word;
    logic [31:0] s_word;
    logic [31:0] exp_rx;
    logic [31:0] exp_master;
  } vec_t;

  localparam int NV = 8;
  vec_t vt [NV];

  initial begin
    logic [31:0] got;
    int base, ubase, abase, w;
    bit sel, msbf;

    vt[0] = '{1'b0, 1'b0, 1'b0, 32'h3C,   32'hA5,   32'h3C,   32'hA5};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h8001, 32'h1234, 32'h8001, 32'h1234};
    vt[2] = '{1'b1, 1'b0, 1'b1, 32'h8001, 32'h1234, 32'h8001, 32'h1234};
    vt[3] = '{1'b1, 1'b1, 1'b0, 32'h8001, 32'h1234, 32'h8001, 32'h1234};
    vt[4] = '{1'b1, 1'b1, 1'b1, 32'h8001, 32'h1234, 32'h8001, 32'h1234};
    vt[5] = '{1'b0, 1'b1, 1'b1, 32'h96,   32'h0F,   32'h96,   32'h0F};
    vt[6] = '{1'b0, 1'b0, 1'b1, 32'h5B,   32'h81,   32'h5B,   32'h81};
    vt[7] = '{1'b0, 1'b1, 1'b0, 32'h01,   32'hFE,   32'h01,   32'hFE};

    // Reset state
    clk_wait(3);
    check("rst_rx_data8", rx_data8, 0);
    check("rst_rx_data16", rx_data16, 0);
    check("rst_tx_ready8", tx_ready8, 1);
    check("rst_tx_ready16", tx_ready16, 1);
    check("rst_pulses8", {rx_valid8, tx_underrun8, frame_abort8, busy8, miso8}, 0);
    check("rst_pulses16", {rx_valid16, tx_underrun16, frame_abort16, busy16, miso16}, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("rst_miso_oe", {miso_oe8, miso_oe16}, 0);
`endif
    rst_n = 1'b1;
    clk_wait(6);
    check("idle_busy", {busy8, busy16}, 0);

    // Single-word frames in every mode
    for (int v = 0; v < NV; v++) begin
      sel  = vt[v].sel;
      w    = sel ? 16 : 8;
      msbf = !sel;
      set_mode(vt[v].cp, vt[v].ch);
      tx_write(sel, vt[v].s_word);
      base = sel ? rxv16 : rxv8;
      frame_start(sel);
      check($sformatf("v%0d_busy", v), sel ? busy16 : busy8, 1);
      xfer_word(sel, w, w, msbf, vt[v].m_word, got);
      frame_end(sel);
      check($sformatf("v%0d_rx_data", v), sel ? 32'(rx_data16) : 32'(rx_data8), vt[v].exp_rx);
      check($sformatf("v%0d_master_rx", v), got, vt[v].exp_master);
      check($sformatf("v%0d_rx_valid_cnt", v), (sel ? rxv16 : rxv8) - base, 1);
    end

    // Burst of three words, refilled after each load
    set_mode(1'b0, 1'b0);
    tx_write(0, 32'hA1);
    base = rxv8; ubase = und8;
    frame_start(0);
    tx_write(0, 32'hB2);
    xfer_word(0, 8, 8, 1, 32'h11, got);
    check("burst0_master", got, 32'hA1);
    check("burst0_rx", rx_data8, 32'h11);
    tx_write(0, 32'hC3);
    xfer_word(0, 8, 8, 1, 32'h22, got);
    check("burst1_master", got, 32'hB2);
    check("burst1_rx", rx_data8, 32'h22);
    tx_write(0, 32'hEE);
    xfer_word(0, 8, 8, 1, 32'h33, got);
    check("burst2_master", got, 32'hC3);
    check("burst2_rx", rx_data8, 32'h33);
    frame_end(0);
    check("burst_rx_valid_cnt", rxv8 - base, 3);
    check("burst_underrun_cnt", und8 - ubase, 0);

    // Underrun on the second word
    tx_write(0, 32'h5A);
    base = rxv8; ubase = und8;
    frame_start(0);
    xfer_word(0, 8, 8, 1, 32'h3C, got);
    check("und0_master", got, 32'h5A);
    check("und0_underrun_cnt", und8 - ubase, 1);
    xfer_word(0, 8, 8, 1, 32'hC3, got);
    check("und1_master", got, 32'h00);
    check("und1_rx", rx_data8, 32'hC3);
    frame_end(0);
    check("und_rx_valid_cnt", rxv8 - base, 2);

    // Abort after 5 of 8 bits, then a clean frame
    tx_write(0, 32'h77);
    base = rxv8; abase = abt8;
    frame_start(0);
    xfer_word(0, 8, 5, 1, 32'hFF, got);
    frame_end(0);
    check("abort_cnt", abt8 - abase, 1);
    check("abort_no_rx_valid", rxv8 - base, 0);
    check("abort_rx_unchanged", rx_data8, 32'hC3);
    check("abort_busy", busy8, 0);
    tx_write(0, 32'h69);
    base = rxv8;
    frame_start(0);
    xfer_word(0, 8, 8, 1, 32'h96, got);
    frame_end(0);
    check("post_abort_rx", rx_data8, 32'h96);
    check("post_abort_master", got, 32'h69);
    check("post_abort_rx_valid_cnt", rxv8 - base, 1);
    check("post_abort_no_abort", abt8 - abase, 1);

    // Reset in the middle of a word with SSN held low
    tx_write(0, 32'h33);
    frame_start(0);
    xfer_word(0, 8, 3, 1, 32'hF0, got);
    rst_n = 1'b0;
    clk_wait(1);
    check("midrst_rx_data", rx_data8, 0);
    check("midrst_tx_ready", tx_ready8, 1);
    check("midrst_outs", {rx_valid8, tx_underrun8, frame_abort8, busy8, miso8}, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("midrst_miso_oe", miso_oe8, 0);
`endif
    rst_n = 1'b1;
    clk_wait(10);
    check("midrst_no_restart", busy8, 0);
    ssn8 = 1'b1;
    clk_wait(8);
    check("idle_miso", miso8, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("idle_miso_oe", miso_oe8, 0);
`endif
    tx_write(0, 32'h4B);
    base = rxv8;
    frame_start(0);
    xfer_word(0, 8, 8, 1, 32'hB4, got);
    frame_end(0);
    check("post_rst_rx", rx_data8, 32'hB4);
    check("post_rst_master", got, 32'h4B);
    check("post_rst_rx_valid_cnt", rxv8 - base, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave: next generation of the team's 8-bit SPI slave, with configurable word width and bit order, all four CPOL/CPHA modes, and multi-word bursts within one SSN-low frame. It also adds a valid/ready transmit holding register and explicit underrun and abort reporting. It sits between the external SPI pins and the on-chip control logic. All SPI inputs are oversampled in the `clk` domain.

## Interface
- `DATA_W`, default 8: word width in bits, legal range 2..32.
- `MSB_FIRST`, default 1: 1 shifts the MSB first on both lines; 0 shifts the LSB first.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low; clock `clk`.
- `cpol` input, 1 bit: SCK idle level.
- `cpha` input, 1 bit: 0 samples on the leading edge, 1 samples on the trailing edge.
- `tx_data` input, DATA_W bits: next word to transmit.
- `tx_valid` input, 1 bit: `tx_data` is valid.
- `tx_ready` output, 1 bit: holding register is empty.
- `rx_data` output, DATA_W bits: last complete received word.
- `rx_valid` output, 1 bit: one-cycle pulse, `rx_data` is updated.
- `tx_underrun` output, 1 bit: one-cycle pulse, a word was loaded with no data in the holding register.
- `frame_abort` output, 1 bit: one-cycle pulse, SSN rose mid-word.
- `busy` output, 1 bit: frame is active.
- `sck` input, 1 bit: SPI clock.
- `ssn` input, 1 bit: slave select, active-low.
- `mosi` input, 1 bit: master data in.
- `miso` output, 1 bit: slave data out.
- `miso_oe` output, 1 bit: MISO output enable. Present only with `SPI_SLAVE_MISO_OE_EN` defined.

## Operation
- **Synchronisers:** `sck`, `ssn` and `mosi` each pass through a 2-FF synchroniser (s-prefixed signals below).
- **Edge detection:** a third register holds the previous `ssck`. An edge is `ssck` differing from that register.
  - Leading edge: `ssck` leaves the `cpol` level.
  - Trailing edge: `ssck` returns to the `cpol` level.
- **Sample and shift edges:** the sample edge is the leading edge when `cpha`=0 and the trailing edge when `cpha`=1. The shift edge is the other one.
- **Mode latch:** `cpol`/`cpha` are latched on the `sssn` falling transition. Changes while the frame is active are ignored.
- **FSM, IDLE -> ACTIVE:** on `sssn` falling.
  - Latch the mode.
  - Clear the bit counter.
  - Load the TX shift register, which consumes the holding register.
  - When `cpha`=0, drive the first bit on `miso` in the same cycle.
- **FSM, ACTIVE -> IDLE:** on `sssn` rising.
- **Sample edge:** shift `smosi` into the RX shift register in MSB_FIRST order and increment the bit counter (0..DATA_W-1).
  - On the DATA_W-th sample edge, copy the RX shift register into `rx_data`, pulse `rx_valid` and wrap the counter to 0.
  - The same edge reloads the TX shift register for the next word. This makes bursts continuous.
- **Shift edge:** drive the next TX bit on `miso`.
  - When `cpha`=1, the first shift edge of each word drives that word's first bit.
  - When `cpha`=0, the first bit is driven at load, so a shift edge that follows the last sample edge of a word is ignored.
- **Holding register:** `tx_ready`=1 when empty. A `tx_valid` & `tx_ready` cycle writes `tx_data` into the register and clears `tx_ready` on the next cycle.
- **Underrun:** if a load finds the holding register empty, the shift register loads all zeros and `tx_underrun` pulses.
- **Simultaneous write and load:** a write in the same cycle as a load bypasses directly into the shift register and counts as no underrun. `tx_ready` stays 1.
- **Abort:** `sssn` rising with bit counter != 0 pulses `frame_abort`.
  - The partial RX word is discarded: no `rx_valid`, and `rx_data` is unchanged.
  - The TX shift register is cleared. The holding register keeps its contents.
- **No RX backpressure:** `rx_data` is overwritten by the next word. The consumer must read it within DATA_W sample edges.

## Timing
- **Reset values:**
  - `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=0.
  - `rx_valid`, `tx_underrun`, `frame_abort` and `busy` all 0.
  - FSM in IDLE, counters 0, holding register empty.
- **Reset mid-frame:** returns to the reset values immediately. After `rst_n` release, the block waits for a fresh `sssn` falling transition.
- **Pin-to-internal latency:** a pin edge on `sck`/`ssn` takes effect 3 `clk` cycles later.
  - `rx_valid` is high exactly one cycle, 3 cycles after the final sample pin edge.
  - `miso` updates 3 cycles after the shift pin edge.
  - `busy` rises 3 cycles after `ssn` falls.
- **Master constraints:**
  - SCK high and low phases are each ≥ 4 `clk` periods.
  - SSN falling to the first SCK edge is ≥ 4 `clk` periods.
  - Last SCK edge to SSN rising is ≥ 4 `clk` periods.
- **Simultaneous events:** SSN rising in the same detect cycle as a final sample edge completes the word (`rx_valid` pulses) and is not an abort.

## Configuration
- **`SPI_SLAVE_MISO_OE_EN` defined:** adds the `miso_oe` output, equal to busy. `miso` is 0 whenever `miso_oe`=0, so the pad can tristate it.
- **Not defined:** no `miso_oe` port. `miso` is driven low in IDLE.
- **Both builds:** all other behaviour is identical.

## Test plan
- **Mode 0 single word:** DATA_W=8, MSB_FIRST=1, `tx_data`=0xA5 preloaded, master sends 0x3C. Expect `rx_data`=0x3C with one `rx_valid` pulse, and the master receives 0xA5.
- **All four modes, LSB first:** DATA_W=16, MSB_FIRST=0, master sends 0x8001, slave sends 0x1234. Expect exact words in all four modes.
- **Burst:** 3 words in one SSN-low frame, slave holding register refilled after each `tx_ready`. Expect 3 `rx_valid` pulses, no `tx_underrun`, correct sequence both directions.
- **Underrun:** second word of a burst with no TX write. Expect `tx_underrun` pulse, master receives 0x00, RX still correct.
- **Abort:** SSN raised after 5 of 8 bits. Expect `frame_abort` pulse, no `rx_valid`, `rx_data` unchanged, next frame correct.
- **Reset mid-word and idle MISO:** `rst_n` asserted mid-word. Expect all outputs at reset values. With `SPI_SLAVE_MISO_OE_EN` defined, also expect `miso_oe`=0 and `miso`=0 while SSN is high.
